alu_cmd_issuer: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_wait_timer.sv | 35 +++
 rtl/alu_cmd_issuer.sv | 132 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: issuer FSM state encoding, function-group codes and a
// helper that extracts the group field from a 4-bit function code.
package alu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } state_e;

  localparam logic [1:0] ARITH_GRP = 2'b00;
  localparam logic [1:0] LOGIC_GRP = 2'b01;
  localparam logic [1:0] CMP_GRP   = 2'b10;
  localparam logic [1:0] SHIFT_GRP = 2'b11;

  localparam int unsigned TimerW = 8;

  function automatic logic [1:0] fun_grp(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Loadable down-counter with synchronous active-low reset; expired_o pulses in
// the enabled cycle where the count reaches its last tick.
module alu_wait_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] load_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = load_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == Width'(1));

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: accept -> one-cycle issue -> wait for result -> hold for consumer.
// Define ALU_CMD_ISSUER_TIMEOUT_EN to return an error result after TIMEOUT_CYC WAIT cycles.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned OPERAND_W   = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [3:0]             CMD_FUN,
  input  logic [OPERAND_W-1:0]   CMD_A,
  input  logic [OPERAND_W-1:0]   CMD_B,
  output logic                   ALU_EN,
  output logic [3:0]             ALU_FUN,
  output logic [OPERAND_W-1:0]   ALU_A,
  output logic [OPERAND_W-1:0]   ALU_B,
  input  logic [2*OPERAND_W-1:0] ALU_OUT,
  input  logic                   ALU_OUT_VALID,
  output logic                   RES_VALID,
  input  logic                   RES_READY,
  output logic [2*OPERAND_W-1:0] RES_DATA,
  output logic [1:0]             RES_GRP,
  output logic                   RES_ERR
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [3:0]             fun_q, fun_d;
  logic [OPERAND_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*OPERAND_W-1:0] data_q, data_d;
  logic [1:0]             grp_q, grp_d;
  logic                   err_q, err_d;
  logic                   accept, timeout, finish;

  // ready_q is a flop so CMD_READY stays low through the reset cycles themselves.
  assign accept = ready_q && CMD_VALID;

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
  alu_wait_timer #(
    .Width(TimerW)
  ) u_wait_timer (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .clr_i    (state_q == StIssue),
    .en_i     (state_q == StWait),
    .load_i   (TimerW'(TIMEOUT_CYC)),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign finish = (state_q == StWait) && (ALU_OUT_VALID || timeout);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (ALU_OUT_VALID || timeout) state_d = StHold;
      StHold:  if (RES_READY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d = (state_d == StIdle);
    fun_d   = fun_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    grp_d   = grp_q;
    err_d   = err_q;
    if (accept) begin
      fun_d = CMD_FUN;
      a_d   = CMD_A;
      b_d   = CMD_B;
    end
    // A real result beats a simultaneous expiry.
    if (finish) begin
      data_d = ALU_OUT_VALID ? ALU_OUT : '0;
      grp_d  = fun_grp(fun_q);
      err_d  = !ALU_OUT_VALID;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ready_q <= 1'b0;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      grp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      grp_q   <= grp_d;
      err_q   <= err_d;
    end
  end

  assign CMD_READY = ready_q;
  assign ALU_EN    = (state_q == StIssue);
  assign RES_VALID = (state_q == StHold);
  assign ALU_FUN   = fun_q;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign RES_DATA  = data_q;
  assign RES_GRP   = grp_q;
  assign RES_ERR   = err_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small delayed-response ALU model.
// Timeout cases run only when ALU_CMD_ISSUER_TIMEOUT_EN is defined.
module tb_alu_cmd_issuer;

  localparam int unsigned W = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           CMD_VALID = 1'b0;
  logic           CMD_READY;
  logic [3:0]     CMD_FUN = '0;
  logic [W-1:0]   CMD_A = '0;
  logic [W-1:0]   CMD_B = '0;
  logic           ALU_EN;
  logic [3:0]     ALU_FUN;
  logic [W-1:0]   ALU_A, ALU_B;
  logic [2*W-1:0] ALU_OUT;
  logic           ALU_OUT_VALID;
  logic           RES_VALID;
  logic           RES_READY = 1'b0;
  logic [2*W-1:0] RES_DATA;
  logic [1:0]     RES_GRP;
  logic           RES_ERR;

  // ALU model: sees ALU_EN at an edge, raises its valid mdl_dly edges later.
  logic           mdl_on = 1'b1;
  int             mdl_dly = 2;
  int             mdl_cnt = 0;
  logic           mdl_vld = 1'b0;
  logic [2*W-1:0] mdl_data = '0;
  logic           force_vld = 1'b0;
  logic [2*W-1:0] force_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    mdl_vld <= 1'b0;
    if (ALU_EN && mdl_on) begin
      mdl_cnt <= mdl_dly;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_vld <= 1'b1;
    end
  end

  assign ALU_OUT_VALID = mdl_vld | force_vld;
  assign ALU_OUT       = force_vld ? force_data : mdl_data;

  alu_cmd_issuer #(
    .OPERAND_W  (W),
    .TIMEOUT_CYC(4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_FUN      (CMD_FUN),
    .CMD_A        (CMD_A),
    .CMD_B        (CMD_B),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .ALU_A        (ALU_A),
    .ALU_B        (ALU_B),
    .ALU_OUT      (ALU_OUT),
    .ALU_OUT_VALID(ALU_OUT_VALID),
    .RES_VALID    (RES_VALID),
    .RES_READY    (RES_READY),
    .RES_DATA     (RES_DATA),
    .RES_GRP      (RES_GRP),
    .RES_ERR      (RES_ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Offer one command; returns positioned at the negedge of the ISSUE cycle.
  task automatic send_cmd(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
    check("ready_before_cmd", CMD_READY, 1);
    CMD_FUN   = fun;
    CMD_A     = a;
    CMD_B     = b;
    CMD_VALID = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  // Edges from the accept edge until RES_VALID is seen, plus ALU_EN pulse count.
  task automatic wait_res(output int lat, output int en_cnt);
    lat    = 0;
    en_cnt = ALU_EN ? 1 : 0;
    while (!RES_VALID && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (ALU_EN) en_cnt++;
    end
    if (!RES_VALID) check("res_valid_bound", 0, 1);
  endtask

  task automatic release_res();
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    check("rel_res_valid_low", RES_VALID, 0);
    check("rel_cmd_ready", CMD_READY, 1);
  endtask

  initial begin
    int lat;
    int en_cnt;
    logic [2*W-1:0] hold_data;

    // Reset values while RST is low
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", CMD_READY, 0);
    check("rst_alu_en", ALU_EN, 0);
    check("rst_alu_fun", ALU_FUN, 0);
    check("rst_alu_a", ALU_A, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res_data", RES_DATA, 0);
    check("rst_res_err", RES_ERR, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_cmd_ready", CMD_READY, 1);

    // Arith command, model answers two cycles after ALU_EN
    mdl_dly  = 2;
    mdl_data = 16'h0046;
    send_cmd(4'b0000, 8'h12, 8'h34);
    check("t1_alu_en", ALU_EN, 1);
    check("t1_alu_a", ALU_A, 8'h12);
    check("t1_alu_b", ALU_B, 8'h34);
    check("t1_cmd_ready_low", CMD_READY, 0);
    wait_res(lat, en_cnt);
    check("t1_latency", lat, 4);
    check("t1_en_pulses", en_cnt, 1);
    check("t1_res_data", RES_DATA, 16'h0046);
    check("t1_res_grp", RES_GRP, 2'b00);
    check("t1_res_err", RES_ERR, 0);
    release_res();

    // Shift group, minimum latency, consumer stalls 5 cycles
    mdl_dly  = 1;
    mdl_data = 16'h0102;
    send_cmd(4'b1101, 8'h81, 8'h03);
    check("t2_alu_fun", ALU_FUN, 4'b1101);
    wait_res(lat, en_cnt);
    check("t2_min_latency", lat, 3);
    hold_data = RES_DATA;
    check("t2_res_data", hold_data, 16'h0102);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("t2_hold_valid", RES_VALID, 1);
      check("t2_hold_data", RES_DATA, 16'h0102);
      check("t2_hold_grp", RES_GRP, 2'b11);
      check("t2_hold_cmd_ready", CMD_READY, 0);
    end
    release_res();

    // Stray valid in IDLE, then in ISSUE
    force_vld  = 1'b1;
    force_data = 16'hDEAD;
    @(negedge CLK);
    force_vld = 1'b0;
    check("t3_idle_pulse_ready", CMD_READY, 1);
    check("t3_idle_pulse_res", RES_VALID, 0);
    check("t3_idle_pulse_en", ALU_EN, 0);
    mdl_dly  = 2;
    mdl_data = 16'h0055;
    send_cmd(4'b0110, 8'h0F, 8'hF0);
    force_vld = 1'b1;
    @(negedge CLK);
    force_vld = 1'b0;
    check("t3_issue_pulse_res", RES_VALID, 0);
    wait_res(lat, en_cnt);
    check("t3_res_data", RES_DATA, 16'h0055);
    check("t3_res_grp", RES_GRP, 2'b01);
    release_res();

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
    // Model silent: error result after 4 WAIT cycles
    mdl_on = 1'b0;
    send_cmd(4'b1000, 8'h01, 8'h02);
    wait_res(lat, en_cnt);
    check("to_latency", lat, 5);
    check("to_res_err", RES_ERR, 1);
    check("to_res_data", RES_DATA, 0);
    check("to_res_grp", RES_GRP, 2'b10);
    release_res();
    // Valid on the 4th WAIT cycle wins over expiry
    mdl_on   = 1'b1;
    mdl_dly  = 3;
    mdl_data = 16'h0777;
    send_cmd(4'b1000, 8'h03, 8'h04);
    wait_res(lat, en_cnt);
    check("to_race_latency", lat, 5);
    check("to_race_err", RES_ERR, 0);
    check("to_race_data", RES_DATA, 16'h0777);
    release_res();
`endif

    // Reset during WAIT, late model valid afterwards
    mdl_dly  = 4;
    mdl_data = 16'hBEEF;
    send_cmd(4'b0111, 8'hA5, 8'h5A);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    check("mr_cmd_ready", CMD_READY, 0);
    check("mr_alu_en", ALU_EN, 0);
    check("mr_alu_fun", ALU_FUN, 0);
    check("mr_alu_a", ALU_A, 0);
    check("mr_alu_b", ALU_B, 0);
    check("mr_res_valid", RES_VALID, 0);
    check("mr_res_data", RES_DATA, 0);
    check("mr_res_grp", RES_GRP, 0);
    check("mr_res_err", RES_ERR, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("mr_late_valid_ignored", RES_VALID, 0);
    end
    check("mr_cmd_ready_after", CMD_READY, 1);

    // Back-to-back with CMD_VALID and RES_READY held high
    mdl_dly   = 2;
    mdl_data  = 16'h0033;
    RES_READY = 1'b1;
    send_cmd(4'b0100, 8'h11, 8'h22);
    CMD_VALID = 1'b1;
    CMD_FUN   = 4'b1000;
    CMD_A     = 8'h55;
    CMD_B     = 8'h66;
    wait_res(lat, en_cnt);
    check("bb_first_data", RES_DATA, 16'h0033);
    check("bb_first_alu_a", ALU_A, 8'h11);
    mdl_data = 16'h00BB;
    @(negedge CLK);
    check("bb_after_hs_res_valid", RES_VALID, 0);
    check("bb_after_hs_ready", CMD_READY, 1);
    check("bb_after_hs_alu_a", ALU_A, 8'h11);
    check("bb_after_hs_alu_b", ALU_B, 8'h22);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    check("bb_second_en", ALU_EN, 1);
    check("bb_second_alu_a", ALU_A, 8'h55);
    check("bb_second_alu_b", ALU_B, 8'h66);
    check("bb_second_fun", ALU_FUN, 4'b1000);
    wait_res(lat, en_cnt);
    check("bb_second_data", RES_DATA, 16'h00BB);
    check("bb_second_grp", RES_GRP, 2'b10);
    @(negedge CLK);
    RES_READY = 1'b0;
    check("bb_end_ready", CMD_READY, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
